serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder for two WIDTH-bit operands that adds one bit per clock, LSB first, using a single 1-bit full adder plus a registered carry. It feeds the full-adder cell one bit pair per cycle and consumes its sum and carry outputs. It is the sequential, area-minimal alternative to a ripple-carry adder in the arithmetic datapath. Operands are loaded on a start strobe, and the result is reported with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand and sum width in bits (≥ 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request to begin an addition; accepted only when busy = 0
- a  input  WIDTH  operand A, sampled at the accepting edge
- b  input  WIDTH  operand B, sampled at the accepting edge
- carry_in  input  1  initial carry, sampled at the accepting edge
- busy  output  1  high while an addition is in progress (SHIFT state)
- done  output  1  one-cycle pulse: sum/carry_out valid
- sum  output  WIDTH  result, low WIDTH bits of a + b + carry_in
- carry_out  output  1  result bit WIDTH

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: processing one bit per cycle.
  - DONE: result published for one cycle.
- IDLE → SHIFT on start = 1.
  - Load the operand shift registers with a and b.
  - Load the carry register with carry_in.
  - Clear the bit counter.
- SHIFT, each edge:
  - Full-adder inputs are the LSB of A, the LSB of B, and the carry register.
  - Shift the fa sum into the MSB of the partial-sum register.
  - Shift A and B right by one.
  - The carry register takes the fa carry_out.
  - Increment the counter.
- SHIFT → DONE on the edge that processes bit WIDTH-1.
  - At that same edge, copy the completed partial sum and the final carry into the sum and carry_out output registers.
- DONE → SHIFT if start = 1, which loads the new operands as in IDLE.
  - Otherwise DONE → IDLE.
- start while busy = 1 is ignored. In-flight operands are not disturbed.
- sum and carry_out change only at completion.
  - They hold their value through IDLE and through any later SHIFT until the next completion.
- Arithmetic is modulo 2^(WIDTH+1), so {carry_out, sum} = a + b + carry_in exactly; there is no overflow flag.
- Counter width is max(1, $clog2(WIDTH)). Terminal count is WIDTH-1.
- WIDTH = 1: SHIFT lasts one cycle.

## Timing
- Reset (rst_n = 0 at an edge) values:
  - state IDLE
  - busy 0, done 0
  - sum 0, carry_out 0
  - carry register 0, counter 0
- Reset mid-operation aborts the addition and discards it. No done is produced.
- busy and done are decoded from the state register: busy = (state == SHIFT), done = (state == DONE).
- Latency:
  - start is sampled at edge E.
  - busy is high for cycles E+1 … E+WIDTH.
  - done is high for exactly the one cycle after edge E+WIDTH.
  - sum and carry_out are valid from that cycle onward.
- Throughput: back-to-back additions are possible by asserting start during the done cycle. This gives one result every WIDTH+1 cycles.
- start high for multiple cycles in IDLE is accepted once. Later cycles fall inside SHIFT and are ignored.
- a, b, and carry_in need to be stable only at the accepting edge.

## Structure
- serial_adder_pkg:
  - state enum type (IDLE, SHIFT, DONE), 2-bit logic.
  - Default WIDTH constant.
- Sub-module: one instance of fa, the existing 1-bit full adder.
  - The carry register, shift registers, counter, and FSM live in serial_adder.
- One always_ff for the state and datapath registers, and one always_comb for next-state logic.
- Every register is assigned in every branch of the reset/else structure.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, carry_in=0, start pulse → busy for 8 cycles, then done pulse with sum=0x96, carry_out=0.
- a=0xFF, b=0x01, carry_in=0 → sum=0x00, carry_out=1. Then a=0xFF, b=0xFF, carry_in=1 → sum=0xFF, carry_out=1.
- Start 0x12+0x34, then assert start with a=0xAA, b=0xAA at cycle E+3 → ignored. Result is 0x46, carry_out=0, with a single done.
- Start 0x80+0x80, drop rst_n at cycle E+4 → all outputs 0, no done. After reset, 0x01+0x02 yields 0x03.
- Assert start during the done cycle with a=0x0F, b=0x01 → done exactly 9 cycles after the previous done, sum=0x10. The previous sum is held until then.
- WIDTH=1 build: a=1, b=1, carry_in=1 → done one cycle after busy, sum=1, carry_out=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between a requester and the serial adder
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - 1-bit full adder cell
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder: one full adder plus a registered carry
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             last_bit;

  fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        // DONE accepts a new start too, giving one result every WIDTH+1 cycles
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.carry_in;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = fa_s;
        a_d               = a_q >> 1;
        b_d               = b_q >> 1;
        carry_d           = fa_c;
        cnt_d             = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          sum_d   = psum_d;
          cout_d  = fa_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH 8 and 1)
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) ifc8 ();
  serial_adder_if #(.WIDTH(1)) ifc1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
    ifc8.start    = 1'b1;
    ifc8.a        = a;
    ifc8.b        = b;
    ifc8.carry_in = cin;
    step();
    ifc8.start    = 1'b0;
  endtask

  // Leaves the bench in the done cycle; counts cycles and busy cycles until then
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (ifc8.done !== 1'b1 && cyc < 30) begin
      if (ifc8.busy === 1'b1) busy_cyc++;
      step();
      cyc++;
    end
  endtask

  task automatic add_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] es, input logic ec);
    int cyc, bc;
    start_op(a, b, cin);
    wait_done(cyc, bc);
    chk({tag, "_latency"}, cyc, 8);
    chk({tag, "_busy"}, bc, 8);
    chk({tag, "_sum"}, ifc8.sum, es);
    chk({tag, "_cout"}, ifc8.carry_out, ec);
    step();
    chk({tag, "_done_pulse"}, ifc8.done, 0);
  endtask

  initial begin
    int cyc, bc, extra_done;
    logic held;
    ifc8.start = 1'b0; ifc8.a = '0; ifc8.b = '0; ifc8.carry_in = 1'b0;
    ifc1.start = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.carry_in = 1'b0;
    step();
    step();
    chk("rst_busy", ifc8.busy, 0);
    chk("rst_done", ifc8.done, 0);
    chk("rst_sum", ifc8.sum, 0);
    chk("rst_cout", ifc8.carry_out, 0);
    chk("rst_w1_sum", ifc1.sum, 0);
    rst_n = 1'b1;
    step();

    add_check("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    add_check("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add_check("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start during SHIFT must not disturb the in-flight operands
    start_op(8'h12, 8'h34, 1'b0);
    step();
    step();
    ifc8.start = 1'b1; ifc8.a = 8'hAA; ifc8.b = 8'hAA;
    step();
    ifc8.start = 1'b0;
    wait_done(cyc, bc);
    chk("ign_latency", cyc, 5);
    chk("ign_sum", ifc8.sum, 8'h46);
    chk("ign_cout", ifc8.carry_out, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ifc8.done === 1'b1 || ifc8.busy === 1'b1) extra_done++;
    end
    chk("ign_single_done", extra_done, 0);

    // reset mid-operation aborts with no done
    start_op(8'h80, 8'h80, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("abort_busy", ifc8.busy, 0);
    chk("abort_done", ifc8.done, 0);
    chk("abort_sum", ifc8.sum, 0);
    chk("abort_cout", ifc8.carry_out, 0);
    rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ifc8.done === 1'b1) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);
    add_check("01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // back-to-back: new start in the done cycle
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(cyc, bc);
    chk("b2b_first_sum", ifc8.sum, 8'h96);
    ifc8.start = 1'b1; ifc8.a = 8'h0F; ifc8.b = 8'h01; ifc8.carry_in = 1'b0;
    step();
    ifc8.start = 1'b0;
    held = 1'b1;
    cyc = 1;
    while (ifc8.done !== 1'b1 && cyc < 30) begin
      if (ifc8.sum !== 8'h96) held = 1'b0;
      step();
      cyc++;
    end
    chk("b2b_spacing", cyc, 9);
    chk("b2b_held", held, 1);
    chk("b2b_sum", ifc8.sum, 8'h10);
    chk("b2b_cout", ifc8.carry_out, 0);
    step();

    // WIDTH=1 instance
    ifc1.start = 1'b1; ifc1.a = 1'b1; ifc1.b = 1'b1; ifc1.carry_in = 1'b1;
    step();
    ifc1.start = 1'b0;
    chk("w1_busy", ifc1.busy, 1);
    chk("w1_sum_held", ifc1.sum, 0);
    step();
    chk("w1_done", ifc1.done, 1);
    chk("w1_busy_off", ifc1.busy, 0);
    chk("w1_sum", ifc1.sum, 1);
    chk("w1_cout", ifc1.carry_out, 1);
    step();
    chk("w1_done_pulse", ifc1.done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
